// File: rtl/apb_master.sv
// CPU-to-APB3 bridge: takes one load/store from the CPU data port, runs it as a
// SETUP/ACCESS transfer to one of four slaves, and returns data, done and error.
module apb_master #(
    parameter logic [15:0] BASE_HI = 16'h1000,
    parameter int          TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PENABLE,
    output logic [3:0]  PSEL,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic [3:0]  PREADY
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       sel, sel_nxt;
    logic             mapped, mapped_nxt;

    logic [31:0] rdata_nxt, paddr_nxt, pwdata_nxt;
    logic        ready_nxt, err_nxt, busy_nxt, pwrite_nxt, penable_nxt;
    logic [3:0]  psel_nxt;

    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        done, done_err;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Route only the selected slave's PREADY/PRDATA back to the FSM.
    always_comb begin
        sel_ready = PREADY[sel];
        case (sel)
            2'd0:    sel_rdata = PRDATA0;
            2'd1:    sel_rdata = PRDATA1;
            2'd2:    sel_rdata = PRDATA2;
            default: sel_rdata = PRDATA3;
        endcase
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sel_nxt     = sel;
        mapped_nxt  = mapped;
        rdata_nxt   = rdata;
        ready_nxt   = 1'b0;
        err_nxt     = 1'b0;
        busy_nxt    = busy;
        paddr_nxt   = PADDR;
        pwrite_nxt  = PWRITE;
        pwdata_nxt  = PWDATA;
        penable_nxt = PENABLE;
        psel_nxt    = PSEL;
        done        = 1'b0;
        done_err    = 1'b0;

        case (state)
            IDLE: begin
                busy_nxt    = 1'b0;
                psel_nxt    = 4'b0000;
                penable_nxt = 1'b0;
                if (transfer) begin
                    paddr_nxt  = addr;
                    pwrite_nxt = write;
                    pwdata_nxt = wdata;
                    sel_nxt    = addr[13:12];
                    mapped_nxt = (addr[31:16] == BASE_HI) && (addr[15:14] == 2'b00);
                    psel_nxt   = mapped_nxt ? onehot(addr[13:12]) : 4'b0000;
                    busy_nxt   = 1'b1;
                    state_nxt  = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                cnt_nxt     = '0;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                // An unmapped address aborts after one ACCESS cycle with no PSEL.
                if (!mapped) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else if (sel_ready) begin
                    done = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (done) begin
            state_nxt   = IDLE;
            psel_nxt    = 4'b0000;
            penable_nxt = 1'b0;
            busy_nxt    = 1'b0;
            ready_nxt   = 1'b1;
            err_nxt     = done_err;
            if (done_err)
                rdata_nxt = 32'h0;
            else if (!PWRITE)
                rdata_nxt = sel_rdata;
        end
    end

    // State and output registers; reset drops any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            sel     <= 2'd0;
            mapped  <= 1'b0;
            rdata   <= 32'h0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            PADDR   <= 32'h0;
            PWRITE  <= 1'b0;
            PWDATA  <= 32'h0;
            PENABLE <= 1'b0;
            PSEL    <= 4'b0000;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sel     <= sel_nxt;
            mapped  <= mapped_nxt;
            rdata   <= rdata_nxt;
            ready   <= ready_nxt;
            err     <= err_nxt;
            busy    <= busy_nxt;
            PADDR   <= paddr_nxt;
            PWRITE  <= pwrite_nxt;
            PWDATA  <= pwdata_nxt;
            PENABLE <= penable_nxt;
            PSEL    <= psel_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with simple APB slave models and a scoreboard
// of expected completions.
module tb_apb_master;

    localparam int TO = 16;

    logic        PCLK;
    logic        PRESET;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic [3:0]  PREADY;

    apb_master #(.BASE_HI(16'h1000), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .busy(busy),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PENABLE(PENABLE), .PSEL(PSEL),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave 0: 16-word RAM, slave 1: one register; both ready after one wait.
    // Slave 2 never ready, slave 3 always ready but never addressed.
    logic [31:0] mem [16];
    logic [31:0] reg1 = 32'h0;
    logic [1:0]  rdy_q;

    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            rdy_q <= 2'b00;
        end else begin
            rdy_q[0] <= PSEL[0] & PENABLE & ~rdy_q[0];
            rdy_q[1] <= PSEL[1] & PENABLE & ~rdy_q[1];
        end
    end

    always @(posedge PCLK) begin
        if (PSEL[0] && PENABLE && PREADY[0] && PWRITE) mem[PADDR[5:2]] <= PWDATA;
        if (PSEL[1] && PENABLE && PREADY[1] && PWRITE) reg1 <= PWDATA;
    end

    assign PRDATA0 = mem[PADDR[5:2]];
    assign PRDATA1 = reg1;
    assign PRDATA2 = 32'hBAD0_0002;
    assign PRDATA3 = 32'hBAD0_0003;
    assign PREADY  = {1'b1, 1'b0, rdy_q};

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        er;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Every ready pulse retires the oldest expected completion.
    always @(negedge PCLK) begin
        if (ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(ready), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_rdata"}, rdata, e.rd);
                check({e.tag, "_err"}, 32'(err), 32'(e.er));
                check({e.tag, "_cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic drive(input string tag, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_er, input int lat);
        exp_t e;
        transfer = 1'b1;
        write    = wr;
        addr     = a;
        wdata    = wd;
        e.tag = tag;
        e.rd  = exp_rd;
        e.er  = exp_er;
        e.at  = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input bit drop);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge PCLK);
            if (ready) seen = 1'b1;
        end
        check({tag, "_wait"}, 32'(ready), 32'h1);
        if (drop) transfer = 1'b0;
    endtask

    task automatic do_xfer(input string tag, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_er, input int lat);
        @(negedge PCLK);
        drive(tag, wr, a, wd, exp_rd, exp_er, lat);
        wait_done(tag, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET   = 1'b0;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        repeat (2) @(negedge PCLK);
        check("rst_psel", 32'(PSEL), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_paddr", PADDR, 32'h0);
        PRESET = 1'b1;

        // Store with one-wait RAM: cycle-by-cycle bus check.
        @(negedge PCLK);
        drive("st_ram", 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 4);
        @(negedge PCLK);
        check("st_setup_psel", 32'(PSEL), 32'h1);
        check("st_setup_pen", 32'(PENABLE), 32'h0);
        check("st_setup_busy", 32'(busy), 32'h1);
        check("st_setup_pwrite", 32'(PWRITE), 32'h1);
        check("st_setup_paddr", PADDR, 32'h1000_0010);
        check("st_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
        @(negedge PCLK);
        check("st_acc1_pen", 32'(PENABLE), 32'h1);
        check("st_acc1_psel", 32'(PSEL), 32'h1);
        @(negedge PCLK);
        check("st_acc2_pen", 32'(PENABLE), 32'h1);
        check("st_acc2_paddr", PADDR, 32'h1000_0010);
        wait_done("st_ram", 1'b1);
        check("st_done_psel", 32'(PSEL), 32'h0);
        check("st_done_pen", 32'(PENABLE), 32'h0);
        check("st_done_busy", 32'(busy), 32'h0);
        check("st_ram_word4", mem[4], 32'hDEAD_BEEF);

        do_xfer("st_ram0", 1'b1, 32'h1000_0000, 32'hCAFE_F00D, 32'h0, 1'b0, 4);
        do_xfer("ld_ram", 1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);
        check("idle_paddr_kept", PADDR, 32'h1000_0010);

        // Back-to-back: second request accepted in the first's ready cycle.
        @(negedge PCLK);
        drive("b2b_st", 1'b1, 32'h1000_1000, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 4);
        wait_done("b2b_st", 1'b0);
        check("b2b_gap_psel", 32'(PSEL), 32'h0);
        drive("b2b_ld", 1'b0, 32'h1000_0000, 32'h0, 32'hCAFE_F00D, 1'b0, 4);
        @(negedge PCLK);
        check("b2b_ld_psel", 32'(PSEL), 32'h1);
        check("b2b_ld_busy", 32'(busy), 32'h1);
        wait_done("b2b_ld", 1'b1);
        check("b2b_reg1", reg1, 32'h1234_5678);

        // Slave 2 never ready: abort after TO ACCESS cycles.
        @(negedge PCLK);
        drive("tmo", 1'b0, 32'h1000_2004, 32'h0, 32'h0, 1'b1, TO + 2);
        @(negedge PCLK);
        check("tmo_setup_psel", 32'(PSEL), 32'h4);
        for (int i = 0; i < TO; i++) begin
            @(negedge PCLK);
            check("tmo_acc_psel", 32'(PSEL), 32'h4);
            check("tmo_acc_ready", 32'(ready), 32'h0);
        end
        wait_done("tmo", 1'b1);
        check("tmo_done_psel", 32'(PSEL), 32'h0);

        do_xfer("ld_ram2", 1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);

        // Unmapped base: no PSEL, error after one ACCESS cycle.
        @(negedge PCLK);
        drive("unmap", 1'b0, 32'h2000_0000, 32'h0, 32'h0, 1'b1, 3);
        @(negedge PCLK);
        check("unmap_setup_psel", 32'(PSEL), 32'h0);
        check("unmap_setup_busy", 32'(busy), 32'h1);
        @(negedge PCLK);
        check("unmap_acc_psel", 32'(PSEL), 32'h0);
        wait_done("unmap", 1'b1);

        do_xfer("unmap_hi", 1'b1, 32'h1000_4000, 32'h5555_AAAA, 32'h0, 1'b1, 3);

        // Reset in the middle of ACCESS drops the transfer.
        @(negedge PCLK);
        drive("rst_mid", 1'b0, 32'h1000_0010, 32'h0, 32'h0, 1'b0, 4);
        @(negedge PCLK);
        @(negedge PCLK);
        check("rst_mid_pen_before", 32'(PENABLE), 32'h1);
        PRESET = 1'b0;
        #1;
        check("rst_mid_psel", 32'(PSEL), 32'h0);
        check("rst_mid_pen", 32'(PENABLE), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_paddr", PADDR, 32'h0);
        check("rst_mid_rdata", rdata, 32'h0);
        sb.delete();
        transfer = 1'b0;
        repeat (3) @(negedge PCLK);
        check("rst_mid_ready", 32'(ready), 32'h0);
        PRESET = 1'b1;

        do_xfer("post_rst_ld", 1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);

        repeat (3) @(negedge PCLK);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
